sha256_w_stream_reader: RTL
===========================

# sha256_w_stream_reader

Sequential SHA-256 message-schedule reader.
- Accepts one padded 512-bit block per valid/ready handshake.
- Emits the schedule words W0..W(NUM_WORDS-1) one per beat on a valid/ready stream.
- Expands W16 onward on the fly from a 16-word sliding window.
- Sits on the consuming side of the message memory: it drains a block into the iterative round datapath, where the pipelined expander fills one.

## Interface
- NUM_WORDS, 64, number of words emitted per block; legal range 16..64.
- CLK  input  1  rising-edge clock.
- RST  input  1  synchronous, active-high reset.
- blk_valid  input  1  block offered.
- blk_ready  output  1  block accepted when blk_valid && blk_ready.
- blk_in  input  512  block, W0 = blk_in[511:480] … W15 = blk_in[31:0].
- w_valid  output  1  w_out holds a valid word.
- w_ready  input  1  consumer takes word when w_valid && w_ready.
- w_out  output  32  current schedule word.
- w_idx  output  6  index of w_out (0..NUM_WORDS-1).
- w_last  output  1  high with the final word of the block.

## Operation
- State machine:
  - IDLE: blk_ready=1, w_valid=0.
  - STREAM: w_valid=1.
- Internal state: win[0..15] (32-bit each), idx (6-bit).
- IDLE -> STREAM on a block handshake:
  - win[k] <= W_k from blk_in.
  - idx <= 0.
- STREAM outputs: w_out = win[0], w_idx = idx, w_last = (idx == NUM_WORDS-1).
- On a word handshake (w_valid && w_ready) with idx < NUM_WORDS-1:
  - win[k] <= win[k+1] for k = 0..14.
  - win[15] <= σ1(win[14]) + win[9] + σ0(win[1]) + win[0], mod 2^32.
  - idx <= idx+1.
- σ0(x) = ROTR7(x) ^ ROTR18(x) ^ SHR3(x). σ1(x) = ROTR17(x) ^ ROTR19(x) ^ SHR10(x). All adds are 32-bit, carries discarded.
- Last-word handshake (w_last && w_ready):
  - If blk_valid is also high: the new block is loaded, idx <= 0, state stays STREAM (back-to-back).
  - Otherwise: state -> IDLE.
- blk_ready = (state==IDLE) || (w_last && w_ready). This path is combinational from w_ready and is permitted.
- Backpressure: while w_valid && !w_ready, the window, idx, w_out, w_idx and w_last are all held.
- blk_in is sampled only in the handshake cycle; it is don't-care otherwise.
- Reset, including mid-block:
  - State -> IDLE, idx = 0, window cleared to 0.
  - Partial block discarded, no further words emitted.
  - Reset wins over any simultaneous handshake.

## Timing
- Reset values: blk_ready=1, w_valid=0, w_out=0, w_idx=0, w_last=0.
- Latency: block accepted at edge N -> W0 on w_out, w_valid=1 from cycle N+1.
- Throughput with w_ready held high:
  - One word per cycle.
  - NUM_WORDS cycles per block back-to-back (no bubble).
  - NUM_WORDS+1 cycles per block if the next block arrives after the last word.
- w_out, w_idx, w_valid and w_last are driven from registers; only blk_ready has a combinational input path.
- Idle with no block offered: outputs stay at their reset values indefinitely.

## Test plan
- "abc" block (61626380, 13×00000000, 00000018), w_ready=1 -> W0=61626380, W15=00000018, W16=61626380, W17=000F0000, W63 matching the FIPS 180-4 reference model; w_last only on idx 63.
- All-zero block -> 64 words all 00000000; blk_ready returns to 1 on the cycle after the last beat.
- Random w_ready stalls (≈50%) on a random block -> word sequence identical to the unstalled run; w_out stable through every stall.
- Two blocks back-to-back, blk_valid held high -> second block's W0 appears on the cycle after the first block's W63; 128 words in 128 cycles.
- RST asserted at idx=20 mid-stream -> next cycle w_valid=0, blk_ready=1, w_idx=0; a following block restarts cleanly at W0.
- NUM_WORDS=16 build -> only W0..W15 emitted, w_last at idx 15, no expansion words appear.

Source files
------------

// File: rtl/sha256_w_stream_reader.sv
// SHA-256 message-schedule reader: takes one padded 512-bit block and streams
// W0..W(NUM_WORDS-1), expanding W16 onward from a 16-word sliding window.
module sha256_w_stream_reader #(
  parameter int NUM_WORDS = 64
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_in,
  output logic         w_valid,
  input  logic         w_ready,
  output logic [31:0]  w_out,
  output logic [5:0]   w_idx,
  output logic         w_last
);

  localparam logic [5:0] LAST_IDX = 6'(NUM_WORDS - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state_r;
  state_t      state_n;
  logic [31:0] win_r [16];
  logic [5:0]  idx_r;
  logic        last_r;
  logic        valid_r;
  logic        load_s;
  logic        shift_s;
  logic [31:0] expand_s;

  assign w_out   = win_r[0];
  assign w_idx   = idx_r;
  assign w_last  = last_r;
  assign w_valid = valid_r;

  // Next schedule word from the current window
  always_comb begin
    expand_s = sigma1(win_r[14]) + win_r[9] + sigma0(win_r[1]) + win_r[0];
  end

  // Next-state, block acceptance and window-control decode
  always_comb begin
    state_n   = state_r;
    load_s    = 1'b0;
    shift_s   = 1'b0;
    blk_ready = 1'b0;
    case (state_r)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) begin
          load_s  = 1'b1;
          state_n = STREAM;
        end else begin
          state_n = IDLE;
        end
      end
      STREAM: begin
        if (w_ready) begin
          // Last beat frees the window, so a waiting block loads with no bubble
          if (last_r) begin
            blk_ready = 1'b1;
            if (blk_valid) begin
              load_s  = 1'b1;
              state_n = STREAM;
            end else begin
              state_n = IDLE;
            end
          end else begin
            shift_s = 1'b1;
          end
        end else begin
          state_n = STREAM;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, window and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      valid_r <= 1'b0;
      idx_r   <= 6'd0;
      last_r  <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        win_r[k] <= 32'd0;
      end
    end else begin
      state_r <= state_n;
      valid_r <= (state_n == STREAM);
      if (load_s) begin
        for (int k = 0; k < 16; k++) begin
          win_r[k] <= blk_in[511 - 32*k -: 32];
        end
        idx_r  <= 6'd0;
        last_r <= 1'b0;
      end else if (shift_s) begin
        for (int k = 0; k < 15; k++) begin
          win_r[k] <= win_r[k+1];
        end
        win_r[15] <= expand_s;
        idx_r     <= idx_r + 6'd1;
        last_r    <= ((idx_r + 6'd1) == LAST_IDX);
      end else if (state_n == IDLE) begin
        last_r <= 1'b0;
      end else begin
        last_r <= last_r;
      end
    end
  end

endmodule
